// File: rtl/err_ctrl_router_pkg.sv
// Shared encodings for the error-control router: command modes and FSM states.
package err_ctrl_router_pkg;

    typedef enum logic [1:0] {
        MODE_TIMED    = 2'd0,
        MODE_CONT     = 2'd1,
        MODE_PERIODIC = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Index width that stays legal (>=1 bit) even for a single channel.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/err_ctrl_router_decode.sv
// Combinational decode of a global error-control code into {in_range, channel, local code}.
module err_ctrl_decode
    import err_ctrl_router_pkg::*;
#(
    parameter int INW     = 8,
    parameter int OUTW    = 4,
    parameter int NCH     = 4,
    parameter int LOW     = 0,
    parameter int CH_SPAN = 16,
    localparam int CHW    = f_idx_w(NCH)
) (
    input  logic [INW-1:0]  i_ctrl,
    output logic            o_in_range,
    output logic [CHW-1:0]  o_ch,
    output logic [OUTW-1:0] o_local
);

    localparam int SW = $clog2(CH_SPAN);
    localparam int HI = LOW + NCH * CH_SPAN - 1;

    // One extra bit so codes below LOW cannot alias into a valid offset.
    logic [INW:0] w_off;

    assign w_off      = {1'b0, i_ctrl} - (INW+1)'(LOW);
    assign o_in_range = (int'(i_ctrl) >= LOW) && (int'(i_ctrl) <= HI);
    assign o_ch       = CHW'(w_off >> SW);
    assign o_local    = OUTW'(w_off[SW-1:0]);

endmodule

// File: rtl/err_ctrl_router.sv
// Registered multi-channel error-injection router: accepts one command, drives one
// channel's enable/ctrl for a timed, continuous or periodic window, then pulses done.
module err_ctrl_router
    import err_ctrl_router_pkg::*;
#(
    parameter int INW     = 8,
    parameter int OUTW    = 4,
    parameter int NCH     = 4,
    parameter int LOW     = 0,
    parameter int CH_SPAN = 16,
    parameter int CNTW    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [INW-1:0]       i_cfg_ctrl,
    input  logic [1:0]           i_cfg_mode,
    input  logic [CNTW-1:0]      i_cfg_len,
    input  logic                 i_abort,
    output logic [NCH-1:0]       o_sub_err_en,
    output logic [NCH*OUTW-1:0]  o_sub_err_ctrl,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_oor
);

    localparam int CHW = f_idx_w(NCH);

    logic                      w_in_range;
    logic [CHW-1:0]            w_ch;
    logic [OUTW-1:0]           w_local;
    mode_e                     w_mode;

    state_e                    r_state;
    mode_e                     r_mode;
    logic [CNTW-1:0]           r_cnt;
    logic [CNTW-1:0]           r_reload;
    logic [CHW-1:0]            r_ch;
    logic [NCH-1:0]            r_en;
    logic [NCH-1:0][OUTW-1:0]  r_ctrl;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_oor;

    err_ctrl_decode #(
        .INW     (INW),
        .OUTW    (OUTW),
        .NCH     (NCH),
        .LOW     (LOW),
        .CH_SPAN (CH_SPAN)
    ) u_decode (
        .i_ctrl     (i_cfg_ctrl),
        .o_in_range (w_in_range),
        .o_ch       (w_ch),
        .o_local    (w_local)
    );

    // Reserved mode 3 folds into TIMED.
    always_comb begin
        w_mode = MODE_TIMED;
        case (i_cfg_mode)
            2'd1:    w_mode = MODE_CONT;
            2'd2:    w_mode = MODE_PERIODIC;
            default: w_mode = MODE_TIMED;
        endcase
    end

    // Counter runs len-1 .. 0 so len=2^CNTW-1 fits without wrap; len 0 and 1 both give one cycle.
    function automatic logic [CNTW-1:0] f_load(input logic [CNTW-1:0] len);
        return (len == '0) ? '0 : len - CNTW'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_TIMED;
            r_cnt    <= '0;
            r_reload <= '0;
            r_ch     <= '0;
            r_en     <= '0;
            r_ctrl   <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_oor    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_oor  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (i_cfg_valid && r_ready) begin
                        r_ready  <= 1'b0;
                        r_mode   <= w_mode;
                        r_cnt    <= f_load(i_cfg_len);
                        r_reload <= f_load(i_cfg_len);
                        r_ch     <= w_ch;
                        if (w_in_range) begin
                            r_state      <= ST_ACTIVE;
                            r_busy       <= 1'b1;
                            r_en         <= '0;
                            r_en[w_ch]   <= 1'b1;
                            r_ctrl       <= '0;
                            r_ctrl[w_ch] <= w_local;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_oor   <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Abort and natural TIMED expiry share one exit, so they never double-pulse.
                    if (i_abort || (r_mode == MODE_TIMED && r_cnt == '0)) begin
                        r_state <= ST_DONE;
                        r_en    <= '0;
                        r_ctrl  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_mode == MODE_PERIODIC) begin
                        if (r_cnt == '0) begin
                            r_cnt      <= r_reload;
                            r_en[r_ch] <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                            r_en  <= '0;
                        end
                    end else if (r_mode == MODE_TIMED) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_cfg_ready    = r_ready;
    assign o_sub_err_en   = r_en;
    assign o_sub_err_ctrl = r_ctrl;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_oor          = r_oor;

endmodule

// File: tb/tb_err_ctrl_router.sv
// Self-checking bench for err_ctrl_router: table-driven commands with a per-cycle
// expected-output scoreboard, plus reset and LOW=8 decode-boundary sequences.
module tb_err_ctrl_router;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] ctrl;
        logic        busy;
        logic        done;
        logic        oor;
        logic        ready;
    } obs_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic [1:0]  mode;
        logic [15:0] len;
        int          abort_at;
        bit          vld_hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_ctrl = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_len = '0;
    logic        abort = 1'b0;
    logic        cfg_ready, busy, done, oor;
    logic [3:0]  sub_en;
    logic [15:0] sub_ctrl;

    logic        v2 = 1'b0;
    logic [7:0]  c2 = '0;
    logic        ready2, busy2, done2, oor2;
    logic [3:0]  en2;
    logic [15:0] ctrl2;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t sb[$];
    int   sb_tag[$];

    always #5 clk = ~clk;

    err_ctrl_router dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_ctrl(cfg_ctrl), .i_cfg_mode(cfg_mode), .i_cfg_len(cfg_len), .i_abort(abort),
        .o_sub_err_en(sub_en), .o_sub_err_ctrl(sub_ctrl), .o_busy(busy), .o_done(done), .o_oor(oor)
    );

    err_ctrl_router #(.LOW(8)) dut_low8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(v2), .o_cfg_ready(ready2),
        .i_cfg_ctrl(c2), .i_cfg_mode(2'd0), .i_cfg_len(16'd1), .i_abort(1'b0),
        .o_sub_err_en(en2), .o_sub_err_ctrl(ctrl2), .o_busy(busy2), .o_done(done2), .o_oor(oor2)
    );

    function automatic obs_t cur_obs();
        obs_t o;
        o.en = sub_en; o.ctrl = sub_ctrl; o.busy = busy; o.done = done; o.oor = oor; o.ready = cfg_ready;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got en=%b ctrl=%h busy=%b done=%b oor=%b ready=%b, want en=%b ctrl=%h busy=%b done=%b oor=%b ready=%b",
                     name, act.en, act.ctrl, act.busy, act.done, act.oor, act.ready,
                     exp.en, exp.ctrl, exp.busy, exp.done, exp.oor, exp.ready);
        end
    endtask

    // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t e;
            int   t;
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check($sformatf("vec%0d", t), cur_obs(), e);
        end
    end

    // Called while in an IDLE cycle with cfg_ready=1, just after a rising edge.
    task automatic run_cmd(input vec_t v, input int idx);
        int   E, L, P, ch, loc;
        bit   inr;
        obs_t e;
        inr = (v.ctrl < 8'h40);
        ch  = int'(v.ctrl) >> 4;
        loc = int'(v.ctrl) & 15;
        L   = (v.len == 0) ? 1 : int'(v.len);
        P   = int'(v.len);
        if (!inr) E = 1;
        else if (v.mode == 2'd1 || v.mode == 2'd2) E = v.abort_at + 1;
        else begin
            E = L + 1;
            if (v.abort_at > 0 && v.abort_at + 1 < E) E = v.abort_at + 1;
        end
        cfg_valid = 1'b1; cfg_ctrl = v.ctrl; cfg_mode = v.mode; cfg_len = v.len;
        @(posedge clk); #1;
        for (int k = 1; k <= E + 1; k++) begin
            e = '0;
            if (k == E + 1) e.ready = 1'b1;
            else if (k == E) begin e.done = 1'b1; e.oor = !inr; end
            else begin
                e.busy = 1'b1;
                e.ctrl[ch*4 +: 4] = 4'(loc);
                e.en[ch] = (v.mode == 2'd2 && P > 1) ? ((k - 1) % P == 0) : 1'b1;
            end
            sb.push_back(e);
            sb_tag.push_back(idx);
        end
        if (!v.vld_hold) cfg_valid = 1'b0;
        for (int k = 1; k <= E; k++) begin
            abort = (k == v.abort_at) || (v.abort_at < 0 && k == E);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        abort = 1'b0;
    endtask

    // Idle cycles with abort held high: must have no effect.
    task automatic idle_gap(input int n, input int idx);
        obs_t e;
        e = '0; e.ready = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < n; i++) begin
            sb.push_back(e); sb_tag.push_back(idx);
        end
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
        abort = 1'b0;
    endtask

    task automatic low8_case(input logic [7:0] code);
        obs_t act, exp;
        int   off;
        bit   inr;
        inr = (code >= 8'd8) && (code <= 8'd71);
        off = int'(code) - 8;
        v2 = 1'b1; c2 = code;
        @(posedge clk); #1;
        v2 = 1'b0;
        act = '0; act.en = en2; act.ctrl = ctrl2; act.busy = busy2; act.done = done2; act.oor = oor2; act.ready = ready2;
        exp = '0;
        if (inr) begin
            exp.en[off >> 4] = 1'b1;
            exp.ctrl[(off >> 4)*4 +: 4] = 4'(off & 15);
            exp.busy = 1'b1;
        end else begin
            exp.done = 1'b1; exp.oor = 1'b1;
        end
        check($sformatf("low8_%h", code), act, exp);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    vec_t tbl[$];
    obs_t x;

    initial begin
        tbl.push_back('{8'h25, 2'd0, 16'd3,  -1, 1'b0});
        tbl.push_back('{8'h40, 2'd0, 16'd5,  -1, 1'b0});
        tbl.push_back('{8'h0F, 2'd1, 16'd0,   5, 1'b0});
        tbl.push_back('{8'h31, 2'd2, 16'd4,  10, 1'b1});
        tbl.push_back('{8'h10, 2'd0, 16'd0,  -1, 1'b0});
        tbl.push_back('{8'h3A, 2'd0, 16'd2,   2, 1'b0});
        tbl.push_back('{8'h22, 2'd2, 16'd1,   3, 1'b0});
        tbl.push_back('{8'h07, 2'd3, 16'd2,  -1, 1'b1});
        tbl.push_back('{8'hFF, 2'd1, 16'd9,  -1, 1'b0});
        tbl.push_back('{8'h3F, 2'd0, 16'd1,   1, 1'b0});
        tbl.push_back('{8'h2C, 2'd2, 16'd0,   2, 1'b0});
        tbl.push_back('{8'h12, 2'd0, 16'd3,   2, 1'b0});
        tbl.push_back('{8'h00, 2'd0, 16'hFFFF, -1, 1'b0});

        // Reset: ready low during reset, then high after the first edge out of reset.
        #2;
        x = '0; check("reset_hold", cur_obs(), x);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        x = '0; x.ready = 1'b1; check("reset_release", cur_obs(), x);

        // Reset asserted mid-window clears everything immediately.
        cfg_valid = 1'b1; cfg_ctrl = 8'h0F; cfg_mode = 2'd1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #3;
        x = '0; x.en = 4'b0001; x.ctrl = 16'h000F; x.busy = 1'b1; check("cont_before_rst", cur_obs(), x);
        rst_n = 1'b0; #1;
        x = '0; check("rst_mid_window", cur_obs(), x);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        x = '0; x.ready = 1'b1; check("rst_mid_release", cur_obs(), x);

        for (int i = 0; i < tbl.size(); i++) begin
            run_cmd(tbl[i], i);
            if (i % 4 == 0) idle_gap(2, 100 + i);
        end

        for (int i = 0; i < 8; i++) begin
            vec_t r;
            r.ctrl = 8'($urandom_range(0, 79));
            r.mode = 2'($urandom_range(0, 3));
            r.len  = 16'($urandom_range(0, 6));
            r.vld_hold = 1'($urandom_range(0, 1));
            if (r.mode == 2'd1 || r.mode == 2'd2) r.abort_at = $urandom_range(1, 9);
            else if ($urandom_range(0, 1) == 0) r.abort_at = -1;
            else r.abort_at = $urandom_range(1, (r.len == 0) ? 1 : int'(r.len));
            run_cmd(r, 200 + i);
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d records left, want 0", sb.size());
        end

        low8_case(8'h03);
        low8_case(8'h07);
        low8_case(8'h08);
        low8_case(8'h47);
        low8_case(8'h48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
